arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, meaning the data width of each channel in bits (legal 1..32).
REQ-002 SHALL provide parameter N, default 4, meaning the number of input channels (legal 2..8); SELW = $clog2(N).
REQ-003 SHALL provide parameter RR, default 1, meaning the arbitration mode: 1 = round-robin, 0 = fixed priority with lowest index highest.
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports clk and reset.
REQ-005 SHALL provide port clk  input  1  rising-edge clock.
REQ-006 SHALL provide port reset  input  1  synchronous active-high reset.
REQ-007 SHALL provide port in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL provide port in_valid  input  N  per-channel valid.
REQ-009 SHALL provide port in_ready  output  N  per-channel ready; combinational.
REQ-010 SHALL provide port out_data  output  WIDTH  registered selected data.
REQ-011 SHALL provide port out_valid  output  1  registered output valid.
REQ-012 SHALL provide port out_ready  input  1  downstream ready.
REQ-013 SHALL provide port out_sel  output  SELW  registered index of the channel that supplied out_data.

Function
REQ-014 A transfer on any port SHALL occur only on a rising clk edge where valid and ready are both 1.
REQ-015 load = !out_valid | out_ready; the output register SHALL accept a new word only when load=1.
REQ-016 When load=1 and at least one in_valid bit is set, exactly one channel g SHALL be granted; in_ready[g]=1 and all other in_ready bits SHALL be 0.
REQ-017 When load=0 or no in_valid bit is set, in_ready SHALL be all zeros.
REQ-018 in_ready SHALL NOT depend combinationally on in_data.
REQ-019 A grant SHALL register in_data[g], out_sel<=g and out_valid<=1 at the next edge, giving one cycle of latency.
REQ-020 When load=1 and no in_valid bit is set, out_valid SHALL become 0 at the next edge; out_data and out_sel SHALL hold their values.
REQ-021 When out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL hold stable.
REQ-022 Simultaneous consume and refill (out_valid=1, out_ready=1, a request present) SHALL sustain one word per cycle with no bubble.
REQ-023 With RR=0, g SHALL be the lowest index with in_valid set.
REQ-024 With RR=1, a pointer ptr (SELW bits) SHALL define priority order ptr, ptr+1, ..., wrapping modulo N, and g is the first requesting index in that order.
REQ-025 With RR=1, on each grant ptr SHALL become (g+1) mod N; the wrap from N-1 to 0 SHALL be correct for non-power-of-two N.
REQ-026 ptr SHALL be unchanged in cycles with no grant.
REQ-027 With RR=1 and all channels continuously requesting, each channel SHALL be granted exactly once in every N consecutive grants.
REQ-028 A channel's request SHALL NOT be lost or duplicated; each in_valid&in_ready handshake SHALL produce exactly one output word.

Reset
REQ-029 While reset=1 at an edge: out_valid<=0, out_data<=0, out_sel<=0, ptr<=0.
REQ-030 While reset=1, in_ready SHALL be all zeros.
REQ-031 A reset asserted with out_valid=1 and out_ready=0 SHALL discard the held word; no transfer SHALL be reported for it.
REQ-032 The first grant after reset SHALL, in RR mode, start with channel 0 priority.

Verification
REQ-033 Reset: assert reset 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0 throughout.
REQ-034 RR fairness (N=4, WIDTH=4, RR=1): channel i data = i+1, all valid, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 and out_data 1,2,3,4,1,2,3,4, with no bubbles.
REQ-035 Fixed priority (RR=0): in_valid=4'b1010 held, out_ready=1 -> out_sel=1 every cycle and channel 3 is never granted.
REQ-036 Backpressure: grant channel 2 (data 4'hA), then out_ready=0 for 3 cycles -> out_data=A, out_sel=2, out_valid=1 stable and in_ready=0; on release, the next word follows in the same cycle.
REQ-037 Wrap and sparse requests (N=3, RR=1): ptr=2 and in_valid=3'b011 -> grant 0 and ptr becomes 1; then in_valid=3'b100 -> grant 2 and ptr becomes 0.
REQ-038 Mid-operation reset: reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0, and the subsequent RR grant order restarts at channel 0.

Source files
------------

// File: rtl/arb_mux.sv
// arb_mux: N-channel arbiter feeding a single registered output stage.
// Handshake rule for every port: a word moves on a rising clk edge where
// valid and ready are both 1; valid never waits on ready, and in_ready is a
// function of in_valid, out_valid, out_ready, reset and the round-robin
// pointer only, never of in_data.
module arb_mux #(
  parameter  int WIDTH = 4,
  parameter  int N     = 4,
  parameter  int RR    = 1,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_sel
);

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [SELW-1:0]  out_sel_q;
  logic [SELW-1:0]  ptr_q;
  logic [SELW-1:0]  ptr_d;

  logic             load;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;

  // The output register may take a word when empty or being drained.
  assign load = !out_valid_q || out_ready;

  // Search requesters starting at the pointer (RR) or at index 0 (fixed).
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = ((RR != 0) ? int'(ptr_q) : 0) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_valid && in_valid[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = SELW'(idx);
      end
    end
  end

  // Data of the granted channel and the pointer that follows it, with an
  // explicit wrap so non-power-of-two N never reaches an unused index.
  always_comb begin
    grant_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];
    ptr_d      = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + SELW'(1);
  end

  // One-hot ready to the winner only while the output stage can load.
  always_comb begin
    in_ready = '0;
    if (!reset && load && grant_valid) in_ready[grant_idx] = 1'b1;
  end

  // Output register and round-robin pointer; reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else if (load) begin
      if (grant_valid) begin
        out_data_q  <= grant_data;
        out_sel_q   <= grant_idx;
        out_valid_q <= 1'b1;
        if (RR != 0) ptr_q <= ptr_d;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: round-robin N=4 instance with a scoreboard, plus fixed-priority
// N=4 and round-robin N=3 instances checked with directed sequences.
module tb_arb_mux;

  logic clk;
  logic reset;

  // Round-robin, N=4, WIDTH=4
  logic [15:0] rr_data;
  logic [3:0]  rr_valid;
  logic [3:0]  rr_in_ready;
  logic [3:0]  rr_out_data;
  logic        rr_out_valid;
  logic        rr_out_ready;
  logic [1:0]  rr_out_sel;

  // Fixed priority, N=4, WIDTH=4
  logic [15:0] fp_data;
  logic [3:0]  fp_valid;
  logic [3:0]  fp_in_ready;
  logic [3:0]  fp_out_data;
  logic        fp_out_valid;
  logic        fp_out_ready;
  logic [1:0]  fp_out_sel;

  // Round-robin, N=3, WIDTH=4
  logic [11:0] n3_data;
  logic [2:0]  n3_valid;
  logic [2:0]  n3_in_ready;
  logic [3:0]  n3_out_data;
  logic        n3_out_valid;
  logic        n3_out_ready;
  logic [1:0]  n3_out_sel;

  arb_mux #(.WIDTH(4), .N(4), .RR(1)) u_rr (
    .clk(clk), .reset(reset), .in_data(rr_data), .in_valid(rr_valid),
    .in_ready(rr_in_ready), .out_data(rr_out_data), .out_valid(rr_out_valid),
    .out_ready(rr_out_ready), .out_sel(rr_out_sel)
  );

  arb_mux #(.WIDTH(4), .N(4), .RR(0)) u_fp (
    .clk(clk), .reset(reset), .in_data(fp_data), .in_valid(fp_valid),
    .in_ready(fp_in_ready), .out_data(fp_out_data), .out_valid(fp_out_valid),
    .out_ready(fp_out_ready), .out_sel(fp_out_sel)
  );

  arb_mux #(.WIDTH(4), .N(3), .RR(1)) u_n3 (
    .clk(clk), .reset(reset), .in_data(n3_data), .in_valid(n3_valid),
    .in_ready(n3_in_ready), .out_data(n3_out_data), .out_valid(n3_out_valid),
    .out_ready(n3_out_ready), .out_sel(n3_out_sel)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Scoreboard for u_rr: {sel, data} of the word expected in the output stage
  logic [5:0] exp_q[$];
  int         m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle of u_rr: check ready/valid at negedge, score, then step the edge.
  task automatic rr_tick();
    logic [3:0] exp_rdy;
    logic [5:0] e;
    logic       load;
    int         g;
    int         idx;
    @(negedge clk);
    exp_rdy = '0;
    g       = -1;
    load    = (exp_q.size() == 0) || rr_out_ready;
    if (!reset && load) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (g < 0 && rr_valid[idx]) g = idx;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    check("rr_in_ready", {28'd0, rr_in_ready}, {28'd0, exp_rdy});
    check("rr_out_valid", {31'd0, rr_out_valid}, {31'd0, exp_q.size() != 0});
    if (reset) begin
      exp_q.delete();
      m_ptr = 0;
    end else begin
      if (exp_q.size() != 0 && rr_out_ready) begin
        e = exp_q.pop_front();
        check("rr_out_word", {26'd0, rr_out_sel, rr_out_data}, {26'd0, e});
      end
      if (g >= 0) begin
        exp_q.push_back({g[1:0], rr_data[g*4 +: 4]});
        m_ptr = (g + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_ptr = 0;
    reset = 1'b1;
    rr_data = {4'd4, 4'd3, 4'd2, 4'd1};
    fp_data = {4'd4, 4'd3, 4'd2, 4'd1};
    n3_data = {4'd7, 4'd6, 4'd5};
    rr_valid = 4'b1111; fp_valid = 4'b1111; n3_valid = 3'b111;
    rr_out_ready = 1'b0; fp_out_ready = 1'b0; n3_out_ready = 1'b0;
    step();

    // Reset held with every channel requesting
    for (int i = 0; i < 2; i++) begin
      rr_tick();
      check("rst_rr_data", {28'd0, rr_out_data}, 32'd0);
      check("rst_rr_sel", {30'd0, rr_out_sel}, 32'd0);
      check("rst_fp_ready", {28'd0, fp_in_ready}, 32'd0);
      check("rst_n3_ready", {29'd0, n3_in_ready}, 32'd0);
      check("rst_fp_valid", {31'd0, fp_out_valid}, 32'd0);
    end
    reset = 1'b0;
    rr_valid = 4'b0000; rr_out_ready = 1'b1;
    fp_valid = 4'b0000; n3_valid = 3'b000;

    // Fixed priority: channels 1 and 3 requesting, channel 1 always wins
    fp_valid = 4'b1010; fp_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("fp_in_ready", {28'd0, fp_in_ready}, 32'b0010);
      step();
      check("fp_out_sel", {30'd0, fp_out_sel}, 32'd1);
      check("fp_out_data", {28'd0, fp_out_data}, 32'd2);
      check("fp_out_valid", {31'd0, fp_out_valid}, 32'd1);
    end
    fp_valid = 4'b0000;

    // N=3 wrap: grant 1 moves ptr to 2, then sparse requests walk the wrap
    n3_out_ready = 1'b1;
    n3_valid = 3'b010;
    step();
    check("n3_sel_1", {30'd0, n3_out_sel}, 32'd1);
    n3_valid = 3'b011;
    @(negedge clk);
    check("n3_rdy_ptr2", {29'd0, n3_in_ready}, 32'b001);
    step();
    check("n3_sel_0", {30'd0, n3_out_sel}, 32'd0);
    check("n3_data_0", {28'd0, n3_out_data}, 32'd5);
    n3_valid = 3'b100;
    @(negedge clk);
    check("n3_rdy_ptr1", {29'd0, n3_in_ready}, 32'b100);
    step();
    check("n3_sel_2", {30'd0, n3_out_sel}, 32'd2);
    check("n3_data_2", {28'd0, n3_out_data}, 32'd7);
    n3_valid = 3'b111;
    @(negedge clk);
    check("n3_rdy_ptr0", {29'd0, n3_in_ready}, 32'b001);
    step();
    check("n3_sel_wrap", {30'd0, n3_out_sel}, 32'd0);
    n3_valid = 3'b000;

    // Round-robin fairness, all channels requesting, no bubbles
    rr_valid = 4'b1111; rr_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rr_tick();
      check("fair_sel", {30'd0, rr_out_sel}, i % 4);
      check("fair_data", {28'd0, rr_out_data}, (i % 4) + 1);
      check("fair_valid", {31'd0, rr_out_valid}, 32'd1);
    end

    // Backpressure holding channel 2's word, then release with a refill
    rr_data = {4'd4, 4'hA, 4'd2, 4'd1};
    rr_valid = 4'b0100;
    rr_tick();
    check("bp_sel", {30'd0, rr_out_sel}, 32'd2);
    check("bp_data", {28'd0, rr_out_data}, 32'hA);
    rr_valid = 4'b1111; rr_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rr_tick();
      check("bp_hold_sel", {30'd0, rr_out_sel}, 32'd2);
      check("bp_hold_data", {28'd0, rr_out_data}, 32'hA);
      check("bp_hold_valid", {31'd0, rr_out_valid}, 32'd1);
    end
    rr_valid = 4'b0001; rr_out_ready = 1'b1;
    rr_tick();
    check("bp_next_sel", {30'd0, rr_out_sel}, 32'd0);
    check("bp_next_valid", {31'd0, rr_out_valid}, 32'd1);

    // Reset while a word is stalled, then the grant order restarts at 0
    rr_valid = 4'b0010; rr_out_ready = 1'b0;
    rr_tick();
    reset = 1'b1; rr_valid = 4'b1111;
    rr_tick();
    check("mid_rst_valid", {31'd0, rr_out_valid}, 32'd0);
    reset = 1'b0; rr_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rr_tick();
      check("post_rst_sel", {30'd0, rr_out_sel}, i);
    end

    // Random traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      rr_data = 16'($urandom());
      rr_valid = 4'($urandom_range(0, 15));
      rr_out_ready = ($urandom_range(0, 3) != 0);
      rr_tick();
    end
    rr_valid = 4'b0000; rr_out_ready = 1'b1;
    rr_tick();
    rr_tick();
    check("drain_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
